// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank.
// NUM_REGS word registers with byte-strobed writes and single-beat reads.
// The write and read channels run as two independent FSMs. Accesses whose
// word index falls outside the bank complete normally with an SLVERR response.
// All register contents are also exported flat on regs_o for control logic.
module axi4_lite_reg_bank #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int NUM_REGS   = 16
) (
    input  logic                               aclk,
    input  logic                               areset,
    // write address channel
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [ADDR_BYTES*8-1:0]            awaddr,
    input  logic [2:0]                         awprot,
    // write data channel
    input  logic                               wvalid,
    output logic                               wready,
    input  logic [DATA_BYTES*8-1:0]            wdata,
    input  logic [DATA_BYTES-1:0]              wstrb,
    // write response channel
    output logic                               bvalid,
    input  logic                               bready,
    output logic [1:0]                         bresp,
    // read address channel
    input  logic                               arvalid,
    output logic                               arready,
    input  logic [ADDR_BYTES*8-1:0]            araddr,
    input  logic [2:0]                         arprot,
    // read data channel
    output logic                               rvalid,
    input  logic                               rready,
    output logic [DATA_BYTES*8-1:0]            rdata,
    output logic [1:0]                         rresp,
    // flattened register contents, reg i at [i*W +: W]
    output logic [NUM_REGS*DATA_BYTES*8-1:0]   regs_o
);

    localparam int W   = DATA_BYTES * 8;            // register width in bits
    localparam int AW  = ADDR_BYTES * 8;            // address width in bits
    localparam int OFF = $clog2(DATA_BYTES);        // byte-offset bits, ignored
    localparam int IW  = AW - OFF;                  // word-index width
    localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // register storage
    logic [W-1:0]           r_regs [NUM_REGS];

    // write channel state
    wr_state_t              r_wr_state;
    wr_state_t              w_wr_next;
    logic [AW-1:0]          r_awaddr;
    logic [W-1:0]           r_wdata;
    logic [DATA_BYTES-1:0]  r_wstrb;
    logic [1:0]             r_bresp;

    // read channel state
    rd_state_t              r_rd_state;
    rd_state_t              w_rd_next;
    logic [W-1:0]           r_rdata;
    logic [1:0]             r_rresp;

    // handshakes
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;

    // commit path: address/data come either from the bus or from the
    // holding registers, depending on which half arrived first
    logic                   w_commit;
    logic [AW-1:0]          w_cm_addr;
    logic [W-1:0]           w_cm_data;
    logic [DATA_BYTES-1:0]  w_cm_strb;
    logic [IW-1:0]          w_cm_idx;
    logic [RIW-1:0]         w_cm_ridx;
    logic                   w_cm_in_range;

    // read address decode
    logic [IW-1:0]          w_ar_idx;
    logic [RIW-1:0]         w_ar_ridx;
    logic                   w_ar_in_range;

    // protection bits and byte-offset bits carry no meaning for this bank
    logic                   w_unused;
    assign w_unused = ^{awprot, arprot, w_cm_addr[OFF-1:0], araddr[OFF-1:0]};

    //------------------------------------------------------------------
    // Channel outputs decoded straight from FSM state
    //------------------------------------------------------------------
    assign awready = (r_wr_state == W_IDLE) || (r_wr_state == W_HAVE_DATA);
    assign wready  = (r_wr_state == W_IDLE) || (r_wr_state == W_HAVE_ADDR);
    assign bvalid  = (r_wr_state == W_RESP);
    assign bresp   = r_bresp;

    assign arready = (r_rd_state == R_IDLE);
    assign rvalid  = (r_rd_state == R_DATA);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid  & wready;
    assign w_b_hs  = bvalid  & bready;
    assign w_ar_hs = arvalid & arready;
    assign w_r_hs  = rvalid  & rready;

    //------------------------------------------------------------------
    // Address decode for write commit and read request
    //------------------------------------------------------------------
    assign w_cm_addr     = (r_wr_state == W_HAVE_ADDR) ? r_awaddr : awaddr;
    assign w_cm_data     = (r_wr_state == W_HAVE_DATA) ? r_wdata  : wdata;
    assign w_cm_strb     = (r_wr_state == W_HAVE_DATA) ? r_wstrb  : wstrb;
    assign w_cm_idx      = w_cm_addr[AW-1:OFF];
    assign w_cm_ridx     = w_cm_idx[RIW-1:0];
    assign w_cm_in_range = (32'(w_cm_idx) < NUM_REGS);

    assign w_ar_idx      = araddr[AW-1:OFF];
    assign w_ar_ridx     = w_ar_idx[RIW-1:0];
    assign w_ar_in_range = (32'(w_ar_idx) < NUM_REGS);

    //------------------------------------------------------------------
    // Write FSM next-state and commit strobe
    //------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_wr_next = r_wr_state;
        w_commit  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit  = 1'b1;
                    w_wr_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wr_next = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wr_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_w_hs) begin
                    w_commit  = 1'b1;
                    w_wr_next = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (w_aw_hs) begin
                    w_commit  = 1'b1;
                    w_wr_next = W_RESP;
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Write FSM state, holding registers and response code
    //------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_state <= W_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_awaddr <= awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_cm_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    //------------------------------------------------------------------
    // Register array: byte-strobed update on commit
    //------------------------------------------------------------------
    // NOTE: the bank is built from flops, not RAM, and must read back zero
    // after reset, so every entry is cleared in the reset branch.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_cm_in_range) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (w_cm_strb[b]) begin
                    r_regs[w_cm_ridx][b*8 +: 8] <= w_cm_data[b*8 +: 8];
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Read FSM next-state
    //------------------------------------------------------------------
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_DATA;
            R_DATA:  if (w_r_hs)  w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Read FSM state and captured read data; a read coinciding with a
    // write commit sees the pre-write register value
    //------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_state <= R_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                r_rdata <= w_ar_in_range ? r_regs[w_ar_ridx] : '0;
                r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    //------------------------------------------------------------------
    // Flatten register contents for downstream control logic
    //------------------------------------------------------------------
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*W +: W] = r_regs[i];
        end
    end

endmodule
